// File: rtl/fifo_unpack_tx_if.sv
// fifo_unpack_tx_if: block-load and uart_tx byte handshake bundle for fifo_unpack_tx
//   load/block_in/len_in : block request from cipher/display logic
//   tx_done_tick         : uart_tx finished current byte
//   tx_start/tx_data     : byte start pulse and byte to uart_tx
//   busy/done            : block in progress / block finished pulse
interface fifo_unpack_tx_if #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 6
);
  logic                                 load;
  logic [DATA_SIZE*2**ADDR_SPACE_EXP-1:0] block_in;
  logic [ADDR_SPACE_EXP:0]              len_in;
  logic                                 tx_done_tick;
  logic                                 tx_start;
  logic [DATA_SIZE-1:0]                 tx_data;
  logic                                 busy;
  logic                                 done;
  modport slave (
    input  load, block_in, len_in, tx_done_tick,
    output tx_start, tx_data, busy, done
  );
  modport master (
    output load, block_in, len_in, tx_done_tick,
    input  tx_start, tx_data, busy, done
  );
endinterface

// File: rtl/fifo_unpack_tx.sv
// fifo_unpack_tx: unpacks a flat char block and feeds it MSB-char first to uart_tx
//   clk_100MHz : clock
//   reset      : async active-high reset
//   bus        : fifo_unpack_tx_if slave (load/block_in/len_in/tx_done_tick in,
//                tx_start/tx_data/busy/done out)
module fifo_unpack_tx #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 6
) (
  input logic               clk_100MHz,
  input logic               reset,
  fifo_unpack_tx_if.slave   bus
);
  localparam int W  = DATA_SIZE * 2**ADDR_SPACE_EXP;
  localparam int CW = ADDR_SPACE_EXP + 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(2**ADDR_SPACE_EXP);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;
  state_t        r_state, w_next;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_len;
  assign w_len = (bus.len_in > MAX_LEN) ? MAX_LEN : bus.len_in;
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.load) begin
        r_shift <= bus.block_in;
        r_count <= w_len;
      end else if (r_state == WAIT && bus.tx_done_tick) begin
        r_shift <= r_shift << DATA_SIZE;
        r_count <= r_count - CW'(1);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.load ? ((w_len != '0) ? SEND : FINISH) : IDLE;
      SEND:    w_next = WAIT;
      WAIT:    w_next = bus.tx_done_tick ? ((r_count == CW'(1)) ? FINISH : SEND) : WAIT;
      default: w_next = IDLE;
    endcase
  end
  assign bus.tx_start = (r_state == SEND);
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == FINISH);
  assign bus.tx_data  = r_shift[W-1 -: DATA_SIZE];
endmodule

// File: tb/tb_fifo_unpack_tx.sv
// tb_fifo_unpack_tx: directed self-checking bench for fifo_unpack_tx
module tb_fifo_unpack_tx;
  localparam int W = 512;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_start = 0;
  int   n_done = 0;
  int   s0, d0;
  fifo_unpack_tx_if #(.DATA_SIZE(8), .ADDR_SPACE_EXP(6)) f();
  fifo_unpack_tx #(.DATA_SIZE(8), .ADDR_SPACE_EXP(6)) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .bus(f.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (f.tx_start) n_start++;
    if (f.done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] mk3(input logic [7:0] a, b, c);
    logic [W-1:0] v;
    v = '0;
    v[W-1 -: 24] = {a, b, c};
    return v;
  endfunction
  function automatic logic [W-1:0] mk64();
    logic [W-1:0] v;
    for (int i = 0; i < 64; i++) v[W-1-8*i -: 8] = 8'(i);
    return v;
  endfunction
  task automatic send_one(input logic [7:0] b, input int gap);
    chk("start", 32'(f.tx_start), 1);
    chk("data", 32'(f.tx_data), 32'(b));
    chk("busy", 32'(f.busy), 1);
    step();
    chk("start_low", 32'(f.tx_start), 0);
    chk("hold", 32'(f.tx_data), 32'(b));
    repeat (gap) step();
    chk("hold_tick", 32'(f.tx_data), 32'(b));
    f.tx_done_tick = 1'b1;
    step();
    f.tx_done_tick = 1'b0;
  endtask
  task automatic end_block();
    chk("done", 32'(f.done), 1);
    chk("done_busy", 32'(f.busy), 1);
    chk("done_nostart", 32'(f.tx_start), 0);
    step();
    chk("done_low", 32'(f.done), 0);
    chk("idle_busy", 32'(f.busy), 0);
  endtask
  initial begin
    f.load = 1'b0;
    f.block_in = '0;
    f.len_in = '0;
    f.tx_done_tick = 1'b0;
    #2;
    chk("rst_start", 32'(f.tx_start), 0);
    chk("rst_data", 32'(f.tx_data), 0);
    chk("rst_busy", 32'(f.busy), 0);
    chk("rst_done", 32'(f.done), 0);
    step();
    reset = 1'b0;
    step();
    // ABC, tick 10 cycles after each start
    s0 = n_start; d0 = n_done;
    f.block_in = mk3(8'h41, 8'h42, 8'h43);
    f.len_in = 7'd3;
    f.load = 1'b1;
    step();
    f.load = 1'b0;
    send_one(8'h41, 9);
    send_one(8'h42, 9);
    send_one(8'h43, 9);
    end_block();
    chk("abc_starts", 32'(n_start - s0), 3);
    chk("abc_dones", 32'(n_done - d0), 1);
    // async reset mid-WAIT
    f.block_in = mk3(8'h11, 8'h22, 8'h33);
    f.len_in = 7'd3;
    f.load = 1'b1;
    step();
    f.load = 1'b0;
    step();
    chk("pre_rst_busy", 32'(f.busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(f.busy), 0);
    chk("midrst_start", 32'(f.tx_start), 0);
    chk("midrst_done", 32'(f.done), 0);
    chk("midrst_data", 32'(f.tx_data), 0);
    #1 reset = 1'b0;
    s0 = n_start; d0 = n_done;
    step();
    step();
    chk("postrst_busy", 32'(f.busy), 0);
    chk("postrst_starts", 32'(n_start - s0), 0);
    chk("postrst_dones", 32'(n_done - d0), 0);
    // 64 incrementing bytes, then back-to-back load after done
    s0 = n_start; d0 = n_done;
    f.block_in = mk64();
    f.len_in = 7'd64;
    f.load = 1'b1;
    step();
    f.load = 1'b0;
    for (int i = 0; i < 64; i++) send_one(8'(i), i % 3);
    end_block();
    chk("b64_starts", 32'(n_start - s0), 64);
    chk("b64_dones", 32'(n_done - d0), 1);
    f.block_in = mk3(8'h61, 8'h62, 8'h63);
    f.len_in = 7'd2;
    f.load = 1'b1;
    step();
    f.load = 1'b0;
    send_one(8'h61, 1);
    send_one(8'h62, 1);
    end_block();
    // len 0, plus stray ticks in FINISH and IDLE
    s0 = n_start; d0 = n_done;
    f.block_in = mk3(8'h58, 8'h59, 8'h5A);
    f.len_in = 7'd0;
    f.load = 1'b1;
    step();
    f.load = 1'b0;
    chk("len0_done", 32'(f.done), 1);
    chk("len0_start", 32'(f.tx_start), 0);
    f.tx_done_tick = 1'b1;
    step();
    f.tx_done_tick = 1'b0;
    chk("len0_done_low", 32'(f.done), 0);
    chk("fin_tick_data", 32'(f.tx_data), 32'h58);
    f.tx_done_tick = 1'b1;
    step();
    f.tx_done_tick = 1'b0;
    chk("idle_tick_data", 32'(f.tx_data), 32'h58);
    chk("idle_tick_busy", 32'(f.busy), 0);
    chk("len0_starts", 32'(n_start - s0), 0);
    chk("len0_dones", 32'(n_done - d0), 1);
    // len 70 clamps to 64
    s0 = n_start; d0 = n_done;
    f.block_in = mk64();
    f.len_in = 7'd70;
    f.load = 1'b1;
    step();
    f.load = 1'b0;
    for (int i = 0; i < 64; i++) send_one(8'(i), 0);
    end_block();
    chk("clamp_starts", 32'(n_start - s0), 64);
    chk("clamp_dones", 32'(n_done - d0), 1);
    // load + tick together in IDLE: load wins
    f.block_in = mk3(8'h70, 8'h71, 8'h72);
    f.len_in = 7'd1;
    f.load = 1'b1;
    f.tx_done_tick = 1'b1;
    step();
    f.load = 1'b0;
    f.tx_done_tick = 1'b0;
    send_one(8'h70, 0);
    end_block();
    // load while busy ignored; stray tick in SEND ignored
    s0 = n_start;
    f.block_in = mk3(8'h41, 8'h42, 8'h43);
    f.len_in = 7'd3;
    f.load = 1'b1;
    step();
    chk("busy_start", 32'(f.tx_start), 1);
    chk("busy_data", 32'(f.tx_data), 32'h41);
    f.block_in = mk3(8'h5A, 8'h5B, 8'h5C);
    f.len_in = 7'd5;
    f.tx_done_tick = 1'b1;
    step();
    f.tx_done_tick = 1'b0;
    chk("send_tick_data", 32'(f.tx_data), 32'h41);
    step();
    chk("busy_load_data", 32'(f.tx_data), 32'h41);
    f.load = 1'b0;
    f.tx_done_tick = 1'b1;
    step();
    f.tx_done_tick = 1'b0;
    send_one(8'h42, 2);
    send_one(8'h43, 2);
    end_block();
    chk("busy_load_starts", 32'(n_start - s0), 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
